// File: rtl/aes_out_unloader_if.sv
// Bus-side bundle of the AES output unloader: launch/capture inputs and the
// 64-bit read port with its status flags.
interface aes_out_unloader_if;
  logic         launch;
  logic [127:0] aes_out;
  logic         clear;
  logic         rd_en;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic         rd_half;
  logic         fifo_full;
  logic         busy;
  logic         overflow;

  modport master (
    output launch, aes_out, clear, rd_en,
    input  rd_data, rd_valid, rd_half, fifo_full, busy, overflow
  );

  modport slave (
    input  launch, aes_out, clear, rd_en,
    output rd_data, rd_valid, rd_half, fifo_full, busy, overflow
  );
endinterface

// File: rtl/aes_out_unloader.sv
// Tracks blocks through the fixed-latency AES pipeline, buffers each emerging
// ciphertext in a small FIFO and hands it back as low then high 64-bit words.
module aes_out_unloader #(
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              reset_in,
  aes_out_unloader_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] vp;
  logic [127:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               rd_half_q;
  logic               overflow_q;

  logic capture;
  logic full;
  logic empty;
  logic advance;
  logic pop;
  logic accept;

  assign capture = vp[LATENCY-1];
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign advance = bus.rd_en && !empty;
  assign pop     = advance && rd_half_q;
  // A pop on the same edge frees the slot the capture needs.
  assign accept  = capture && (!full || pop);

  // NOTE: storage has no reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (accept && !bus.clear) mem[wr_ptr] <= bus.aes_out;
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      vp         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_half_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      vp         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_half_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      vp <= {vp[LATENCY-2:0], bus.launch};
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (capture && !accept) overflow_q <= 1'b1;
      if (advance) rd_half_q <= ~rd_half_q;
    end
  end

  // rd_data is forced to zero when empty so reset shows a clean bus.
  assign bus.rd_valid  = !empty;
  assign bus.rd_data   = empty     ? 64'd0 :
                         rd_half_q ? mem[rd_ptr][127:64] : mem[rd_ptr][63:0];
  assign bus.rd_half   = rd_half_q;
  assign bus.fifo_full = full;
  assign bus.busy      = |vp;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_aes_out_unloader.sv
// Directed bench for aes_out_unloader: single block, burst overflow, full+pop,
// clear, async reset and idle reads, with hand-computed expectations.
module tb_aes_out_unloader;

  localparam int L = 21;

  logic clk;
  logic reset_in;
  int   checks;
  int   errors;

  aes_out_unloader_if bus ();

  aes_out_unloader #(.LATENCY(L), .FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rd_valid"},  bus.rd_valid,  1'b0);
    check({tag, " rd_half"},   bus.rd_half,   1'b0);
    check({tag, " fifo_full"}, bus.fifo_full, 1'b0);
    check({tag, " busy"},      bus.busy,      1'b0);
    check({tag, " overflow"},  bus.overflow,  1'b0);
    check({tag, " rd_data"},   bus.rd_data,   64'd0);
  endtask

  // Reads one 128-bit entry as low word then high word.
  task automatic read_block(input string tag, input logic [127:0] blk);
    check({tag, " valid"}, bus.rd_valid, 1'b1);
    check({tag, " half0"}, bus.rd_half,  1'b0);
    check({tag, " lo"},    bus.rd_data,  blk[63:0]);
    bus.rd_en = 1'b1;
    tick();
    check({tag, " half1"}, bus.rd_half,  1'b1);
    check({tag, " hi"},    bus.rd_data,  blk[127:64]);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic launch_n(input int n);
    bus.launch = 1'b1;
    step(n);
    bus.launch = 1'b0;
  endtask

  localparam logic [127:0] T1 = 128'hA5A5A5A5A5A5A5A5_A5A5A5A5A5A50123;
  localparam logic [127:0] D1 = 128'h1111111111111111_2222222222222222;
  localparam logic [127:0] D2 = 128'h3333333333333333_4444444444444444;
  localparam logic [127:0] D3 = 128'h5555555555555555_6666666666666666;

  initial begin
    checks       = 0;
    errors       = 0;
    reset_in     = 1'b1;
    bus.launch   = 1'b0;
    bus.aes_out  = '0;
    bus.clear    = 1'b0;
    bus.rd_en    = 1'b0;
    #1;
    check_idle("reset");
    @(negedge clk);
    reset_in = 1'b0;
    #1;

    // 1 single block
    launch_n(1);
    check("t1 busy after launch", bus.busy, 1'b1);
    bus.aes_out = T1;
    step(L - 1);
    check("t1 not yet valid", bus.rd_valid, 1'b0);
    check("t1 busy in flight", bus.busy, 1'b1);
    tick();
    check("t1 busy done", bus.busy, 1'b0);
    read_block("t1", T1);
    check("t1 drained valid", bus.rd_valid, 1'b0);
    check("t1 drained half", bus.rd_half, 1'b0);
    check("t1 drained data", bus.rd_data, 64'd0);

    // 2 burst of three into a two-deep FIFO
    launch_n(3);
    step(L - 3);
    bus.aes_out = D1; tick();
    bus.aes_out = D2; tick();
    check("t2 full before 3rd", bus.fifo_full, 1'b1);
    check("t2 no ovf before 3rd", bus.overflow, 1'b0);
    bus.aes_out = D3; tick();
    check("t2 full", bus.fifo_full, 1'b1);
    check("t2 overflow", bus.overflow, 1'b1);
    read_block("t2 e1", D1);
    check("t2 not full", bus.fifo_full, 1'b0);
    read_block("t2 e2", D2);
    check("t2 empty", bus.rd_valid, 1'b0);
    check("t2 overflow sticky", bus.overflow, 1'b1);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    check("t2 clear ovf", bus.overflow, 1'b0);

    // 3 capture accepted while full because the same edge pops
    launch_n(3);
    step(L - 3);
    bus.aes_out = D1; tick();
    bus.aes_out = D2; bus.rd_en = 1'b1; tick();
    check("t3 full", bus.fifo_full, 1'b1);
    check("t3 half1", bus.rd_half, 1'b1);
    check("t3 e1 hi", bus.rd_data, D1[127:64]);
    bus.aes_out = D3; tick();
    bus.rd_en = 1'b0;
    check("t3 still full", bus.fifo_full, 1'b1);
    check("t3 no overflow", bus.overflow, 1'b0);
    read_block("t3 e2", D2);
    read_block("t3 e3", D3);
    check("t3 empty", bus.rd_valid, 1'b0);

    // 4 clear kills the in-flight block
    bus.aes_out = T1;
    launch_n(1);
    step(4);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    check("t4 busy cleared", bus.busy, 1'b0);
    step(L);
    check_idle("t4");

    // 5 async reset with two entries buffered and rd_half=1
    launch_n(2);
    step(L - 2);
    bus.aes_out = D1; tick();
    bus.aes_out = D2; tick();
    check("t5 full", bus.fifo_full, 1'b1);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    check("t5 half1", bus.rd_half, 1'b1);
    #3 reset_in = 1'b1;
    #1 check_idle("t5 async");
    #1 reset_in = 1'b0;
    launch_n(1);
    step(5);
    #3 reset_in = 1'b1;
    #1 check("t5 busy reset", bus.busy, 1'b0);
    #1 reset_in = 1'b0;
    step(L + 2);
    check_idle("t5 no late capture");

    // 6 reads while empty are ignored
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6 half", bus.rd_half, 1'b0);
      check("t6 valid", bus.rd_valid, 1'b0);
    end
    bus.rd_en = 1'b0;
    check_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
